// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch controller sitting between the program counter and decode. Issues a
// req/ack read of instruction memory at the current PC. It latches the returned
// word into the instruction register and presents it to decode over a
// valid/ready handshake. It also drives the PC increment/load controls,
// including branch redirects and dropping wrong-path fetches.
//
// Ports
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   enable         : fetch permitted (blocks only the start of a new fetch)
//   pc             : current program counter
//   inc_pc         : PC+1 strobe (combinational, forced low in reset)
//   load_pc        : PC load strobe, mirrors branch_taken (forced low in reset)
//   new_count      : PC load value, equals branch_target
//   branch_taken   : single-cycle redirect pulse
//   branch_target  : redirect address
//   mem_req        : memory read request, held until mem_ack
//   mem_addr       : registered request address
//   mem_ack        : one-cycle acknowledge, mem_rdata valid with it
//   mem_rdata      : instruction word ([15:12] opcode)
//   ir, ir_valid   : instruction register and its valid flag
//   ir_ready       : decode accepts ir
//
// Build option
//   FETCH_HALT_EN  : when defined, an accepted opcode 4'b1111 parks the
//                    fetcher in HALT until a branch redirects it.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    localparam int unsigned ADDR_W = 8,
    localparam int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc,
    output logic              inc_pc,
    output logic              load_pc,
    output logic [ADDR_W-1:0] new_count,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REQ,
`ifdef FETCH_HALT_EN
        S_HALT,
`endif
        S_VALID
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   ir_q;
    logic                ir_valid_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                discard_q;   // a branch arrived while the current read was outstanding

`ifdef FETCH_HALT_EN
    logic halt_hit;
    assign halt_hit = (ir_q[DATA_W-1 -: 4] == 4'hF);
`endif

    // Data from an ack is kept only if no redirect happened during or at the ack.
    logic ack_keep;
    assign ack_keep = mem_ack && !discard_q && !branch_taken;

    // PC controls; mutually exclusive because ack_keep excludes branch_taken.
    assign inc_pc    = !reset && (state_q == S_REQ) && ack_keep;
    assign load_pc   = !reset && branch_taken;
    assign new_count = branch_target;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;

    // Fetch FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_q <= S_ADDR;
                end

                // A redirect here means pc is stale; recapture it next cycle.
                S_ADDR: begin
                    mem_addr_q <= pc;
                    if (!branch_taken) begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        discard_q <= 1'b0;
                        if (discard_q || branch_taken) begin
                            state_q <= S_ADDR;
                        end else begin
                            ir_q       <= mem_rdata;
                            ir_valid_q <= 1'b1;
                            state_q    <= S_VALID;
                        end
                    end else if (branch_taken) begin
                        discard_q <= 1'b1;
                    end
                end

                // Branch wins over ready: the held word is wrong-path.
                S_VALID: begin
                    if (branch_taken) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= S_ADDR;
                    end else if (ir_ready) begin
                        ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
                        if (halt_hit) state_q <= S_HALT;
                        else
`endif
                        if (enable) state_q <= S_ADDR;
                        else        state_q <= S_IDLE;
                    end
                end

`ifdef FETCH_HALT_EN
                S_HALT: begin
                    if (branch_taken) state_q <= S_ADDR;
                end
`endif

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Bench for instruction_fetch. The environment models the program counter and a
// memory with variable wait states. An architectural scoreboard tracks the
// address decode should see next: it advances on every accepted instruction and
// jumps on every branch. Directed steps come first, then a randomized run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  pc;
    logic        inc_pc;
    logic        load_pc;
    logic [7:0]  new_count;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pc           (pc),
        .inc_pc       (inc_pc),
        .load_pc      (load_pc),
        .new_count    (new_count),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [256];
    logic [7:0]  ptr;            // address of the next instruction decode should get
    bit          req_active = 1'b0;
    int          wait_left = 0;
    logic [7:0]  req_addr = 8'h00;
    int          force_wait = -1;
    int          accepted = 0;
    int          inc_count = 0;
    int          req_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check/sample before the edge, update PC and memory after it.
    task automatic cycle();
        bit         c_inc;
        bit         c_load;
        logic [7:0] c_tgt;
        #1;
        chk("load_pc", 32'(load_pc), reset ? 32'd0 : 32'(branch_taken));
        chk("new_count", 32'(new_count), 32'(branch_target));
        chk("inc_load_excl", 32'(inc_pc & load_pc), 32'd0);
        if (inc_pc) chk("inc_needs_ack", 32'(mem_ack), 32'd1);
        if (ir_valid) chk("ir_content", 32'(ir), 32'(mem[ptr]));
        if (ir_valid && ir_ready && !branch_taken) begin
            accepted++;
            ptr = ptr + 8'd1;
        end
        if (branch_taken && !reset) ptr = branch_target;
        if (mem_req) req_cycles++;
        c_inc  = inc_pc;
        c_load = load_pc;
        c_tgt  = branch_target;
        if (c_inc) inc_count++;
        if (mem_ack) req_active = 1'b0;
        @(posedge clk);
        #1;
        if (c_load)     pc = c_tgt;
        else if (c_inc) pc = pc + 8'd1;
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        if (reset) begin
            req_active = 1'b0;
        end else if (mem_req) begin
            if (!req_active) begin
                req_active = 1'b1;
                req_addr   = mem_addr;
                wait_left  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                chk("req_addr_is_pc", 32'(mem_addr), 32'(ptr));
            end else begin
                chk("mem_addr_stable", 32'(mem_addr), 32'(req_addr));
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                wait_left--;
            end
        end
    endtask

    initial begin
        int         edges;
        int         inc0;
        int         r0;
        int         vseen;
        logic [15:0] saved;
        bit         last_br;

        for (int i = 0; i < 256; i++)
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        mem[8'h10] = 16'h1234;
        mem[8'hA0] = 16'hF000;

        reset = 1'b1; enable = 1'b0; pc = 8'h10; ptr = 8'h10;
        branch_taken = 1'b1; branch_target = 8'h55;
        mem_ack = 1'b0; mem_rdata = 16'h0; ir_ready = 1'b0;

        // Reset values, strobes suppressed during reset.
        #2;
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_load_pc", 32'(load_pc), 32'd0);
        chk("rst_inc_pc", 32'(inc_pc), 32'd0);
        branch_taken = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;

        // Basic zero-wait fetch at 0x10.
        force_wait = 0;
        enable = 1'b1;
        inc0 = inc_count; edges = 0;
        while (!ir_valid && edges < 10) begin cycle(); edges++; end
        chk("basic_latency", 32'(edges), 32'd3);
        chk("basic_ir", 32'(ir), 32'h1234);
        chk("basic_inc", 32'(inc_count - inc0), 32'd1);
        chk("basic_addr", 32'(mem_addr), 32'h10);

        // Branch while a 4-wait request to 0x11 is outstanding.
        force_wait = 4;
        ir_ready = 1'b1; cycle(); ir_ready = 1'b0;
        edges = 0;
        while (!mem_req && edges < 10) begin cycle(); edges++; end
        chk("br_req_addr", 32'(mem_addr), 32'h11);
        cycle();
        branch_taken = 1'b1; branch_target = 8'h40;
        #1;
        chk("br_load_pc", 32'(load_pc), 32'd1);
        chk("br_new_count", 32'(new_count), 32'h40);
        chk("br_no_inc", 32'(inc_pc), 32'd0);
        cycle();
        branch_taken = 1'b0;
        inc0 = inc_count; vseen = 0; edges = 0;
        while (mem_req && edges < 20) begin cycle(); edges++; if (ir_valid) vseen++; end
        while (!mem_req && edges < 20) begin cycle(); edges++; if (ir_valid) vseen++; end
        chk("br_drop_inc", 32'(inc_count - inc0), 32'd0);
        chk("br_drop_valid", 32'(vseen), 32'd0);
        chk("br_next_addr", 32'(mem_addr), 32'h40);

        // Wait states on the request to 0x40.
        r0 = req_cycles; inc0 = inc_count; edges = 0;
        while (mem_req && edges < 20) begin cycle(); edges++; end
        chk("ws_req_cycles", 32'(req_cycles - r0), 32'd5);
        chk("ws_inc", 32'(inc_count - inc0), 32'd1);
        chk("ws_ir_valid", 32'(ir_valid), 32'd1);
        chk("ws_ir", 32'(ir), 32'(mem[8'h40]));

        // Branch and ready together in VALID: branch wins.
        force_wait = 0;
        branch_taken = 1'b1; branch_target = 8'h80; ir_ready = 1'b1;
        r0 = accepted;
        cycle();
        branch_taken = 1'b0; ir_ready = 1'b0;
        chk("bvr_no_accept", 32'(accepted - r0), 32'd0);
        chk("bvr_valid_fell", 32'(ir_valid), 32'd0);
        edges = 0;
        while (!mem_req && edges < 10) begin cycle(); edges++; end
        chk("bvr_addr", 32'(mem_addr), 32'h80);
        edges = 0;
        while (!ir_valid && edges < 10) begin cycle(); edges++; end
        chk("bvr_ir", 32'(ir), 32'(mem[8'h80]));
        enable = 1'b0; ir_ready = 1'b1; cycle(); ir_ready = 1'b0;

        // Stray ack in IDLE is ignored.
        saved = ir;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        cycle();
        chk("stray_ir", 32'(ir), 32'(saved));
        chk("stray_valid", 32'(ir_valid), 32'd0);
        cycle();
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // Halt opcode at 0xA0.
        branch_taken = 1'b1; branch_target = 8'hA0; cycle(); branch_taken = 1'b0;
        enable = 1'b1; force_wait = 1; edges = 0;
        while (!ir_valid && edges < 10) begin cycle(); edges++; end
        chk("halt_presented", 32'(ir), 32'hF000);
        r0 = accepted;
        ir_ready = 1'b1; cycle(); ir_ready = 1'b0;
        chk("halt_accepted", 32'(accepted - r0), 32'd1);
`ifdef FETCH_HALT_EN
        r0 = req_cycles;
        repeat (20) cycle();
        chk("halt_no_req", 32'(req_cycles - r0), 32'd0);
        chk("halt_no_valid", 32'(ir_valid), 32'd0);
        branch_taken = 1'b1; branch_target = 8'h00; cycle(); branch_taken = 1'b0;
        edges = 0;
        while (!mem_req && edges < 10) begin cycle(); edges++; end
        chk("halt_resume_lat", 32'(edges), 32'd1);
        chk("halt_resume_addr", 32'(mem_addr), 32'h00);
`else
        edges = 0;
        while (!mem_req && edges < 10) begin cycle(); edges++; end
        chk("nohalt_next_lat", 32'(edges), 32'd1);
        chk("nohalt_next_addr", 32'(mem_addr), 32'hA1);
`endif
        edges = 0;
        while (!ir_valid && edges < 10) begin cycle(); edges++; end
        chk("post_halt_valid", 32'(ir_valid), 32'd1);

        // Reset in the middle of a request.
        force_wait = 6;
        ir_ready = 1'b1; cycle(); ir_ready = 1'b0;
        edges = 0;
        while (!mem_req && edges < 10) begin cycle(); edges++; end
        cycle();
        reset = 1'b1; branch_taken = 1'b1;
        #1;
        chk("mrst_mem_req", 32'(mem_req), 32'd0);
        chk("mrst_ir_valid", 32'(ir_valid), 32'd0);
        chk("mrst_ir", 32'(ir), 32'd0);
        chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mrst_inc_pc", 32'(inc_pc), 32'd0);
        chk("mrst_load_pc", 32'(load_pc), 32'd0);
        branch_taken = 1'b0;
        cycle();
        reset = 1'b0; pc = 8'h20; ptr = 8'h20; enable = 1'b0;
        repeat (3) cycle();
        chk("mrst_idle", 32'(mem_req), 32'd0);
        enable = 1'b1; force_wait = -1; edges = 0;
        while (!mem_req && edges < 10) begin cycle(); edges++; end
        chk("mrst_restart_lat", 32'(edges), 32'd2);
        chk("mrst_restart_addr", 32'(mem_addr), 32'h20);

        // Randomized traffic against the scoreboard.
        r0 = accepted; last_br = 1'b0;
        for (int n = 0; n < 800; n++) begin
            enable        = ($urandom_range(0, 7) != 0);
            ir_ready      = 1'($urandom_range(0, 1));
            branch_taken  = !last_br && ($urandom_range(0, 15) == 0);
            branch_target = 8'($urandom);
            last_br       = branch_taken;
            cycle();
        end
        branch_taken = 1'b0;
        chk("random_progress", 32'(accepted - r0 > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
